// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. An idle arbiter
//   grants one valid requester (round-robin on ties) and latches its
//   operands. It then drives the ALU for one cycle, captures the result and
//   holds it on the winner's response channel until that requester takes it.
//   Opcodes 1100-1111 are illegal. For an illegal opcode the response is
//   result 0, zero 1, err 1.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req{0,1}_valid/_ready         request handshake
//   req{0,1}_a/_b/_ctr            operands and 4-bit ALU opcode
//   rsp{0,1}_valid/_ready         response handshake
//   rsp{0,1}_result/_zero/_err    captured result, zero flag, illegal-op flag
//   alu_a/_b/_ctr                 drive to the shared ALU (0 outside EXEC)
//   alu_result/_zero              returned from the shared ALU
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctr,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctr,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_sel;
  logic             any_req;
  logic             accept;

  logic [WIDTH-1:0] a_p0, b_p0;
  logic [3:0]       ctr_p0;
  logic             grant_p0;

  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             err_p1;
  logic [WIDTH+1:0] cap;

  // Packs {err, zero, result}. An illegal opcode replaces whatever the ALU
  // returned. A legal one passes the ALU output through untouched.
  function automatic logic [WIDTH+1:0] capture_op(input logic [3:0]       ctr,
                                                  input logic [WIDTH-1:0] res,
                                                  input logic             zero);
    if (ctr[3] && ctr[2]) return {1'b1, 1'b1, {WIDTH{1'b0}}};
    else                  return {1'b0, zero, res};
  endfunction

  // On a tie the requester that did not win last time goes next. A single
  // valid requester always wins.
  always_comb begin
    any_req   = req0_valid | req1_valid;
    grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept    = (state == IDLE) && any_req;
    cap       = capture_op(ctr_p0, alu_result, alu_zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are gated with rst_n so they read 0 for as long as reset is
  // held, even when a request is presented during reset.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_result = '0;
    rsp1_result = '0;
    rsp0_zero   = 1'b0;
    rsp1_zero   = 1'b0;
    rsp0_err    = 1'b0;
    rsp1_err    = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctr     = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            req0_ready = ~grant_sel;
            req1_ready = grant_sel;
            state_nxt  = EXEC;
          end
        end
        EXEC: begin
          alu_a     = a_p0;
          alu_b     = b_p0;
          alu_ctr   = ctr_p0;
          state_nxt = RESP;
        end
        RESP: begin
          if (grant_p0) begin
            rsp1_valid  = 1'b1;
            rsp1_result = res_p1;
            rsp1_zero   = zero_p1;
            rsp1_err    = err_p1;
            if (rsp1_ready) state_nxt = IDLE;
          end else begin
            rsp0_valid  = 1'b1;
            rsp0_result = res_p1;
            rsp0_zero   = zero_p1;
            rsp0_err    = err_p1;
            if (rsp0_ready) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- p0: operand latch at acceptance ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      grant_p0   <= 1'b0;
      a_p0       <= '0;
      b_p0       <= '0;
      ctr_p0     <= '0;
    end else if (accept) begin
      last_grant <= grant_sel;
      grant_p0   <= grant_sel;
      a_p0       <= grant_sel ? req1_a   : req0_a;
      b_p0       <= grant_sel ? req1_b   : req0_b;
      ctr_p0     <= grant_sel ? req1_ctr : req0_ctr;
    end
  end

  // ---- p1: ALU result capture at the end of EXEC ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else if (state == EXEC) begin
      err_p1  <= cap[WIDTH+1];
      zero_p1 <= cap[WIDTH];
      res_p1  <= cap[WIDTH-1:0];
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, as the operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 SHALL have ports reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 SHALL have ports reqN_a, reqN_b  input  WIDTH  operands of requester N.
REQ-007 SHALL have ports reqN_ctr  input  4  ALU opcode of requester N (0000 addu .. 1011 lui).
REQ-008 SHALL have ports rspN_valid  output  1  result for requester N is available.
REQ-009 SHALL have ports rspN_ready  input  1  requester N consumes its result.
REQ-010 SHALL have ports rspN_result  output  WIDTH, rspN_zero  output  1, rspN_err  output  1  result, zero flag and illegal-opcode flag for N.
REQ-011 SHALL have ports alu_a, alu_b  output  WIDTH, alu_ctr  output  4  drive to the shared combinational ALU.
REQ-012 SHALL have ports alu_result  input  WIDTH, alu_zero  input  1  returned from the shared ALU.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: if any reqN_valid, SHALL assert reqN_ready (combinationally) for exactly one granted requester; other ready low.
REQ-015 Arbitration SHALL be round-robin: one valid -> that one wins; both valid -> the requester not equal to last_grant wins.
REQ-016 On valid&ready, SHALL latch a, b, ctr and grant index, update last_grant, go to EXEC.
REQ-017 reqN_ready SHALL be low in EXEC and RESP.
REQ-018 EXEC: alu_a/alu_b/alu_ctr SHALL equal the latched values; at cycle end SHALL capture alu_result and alu_zero, go to RESP.
REQ-019 Outside EXEC, alu_a, alu_b, alu_ctr SHALL be driven to 0.
REQ-020 Opcodes 1100-1111 SHALL be illegal: captured result 0, zero 1, err 1; legal opcodes err 0.
REQ-021 RESP: rspN_valid SHALL be high only for the granted N, with result/zero/err stable until rspN_ready sampled high.
REQ-022 On rspN_valid&rspN_ready, SHALL return to IDLE; a new acceptance cannot occur in that same cycle.
REQ-023 Latency: request accepted at edge T -> rsp_valid high in cycle T+2; minimum issue interval 3 cycles.
REQ-024 reqN_valid changes while not ready SHALL have no effect; operands not sampled after acceptance.
REQ-025 Result width arithmetic SHALL be exactly the ALU's; the arbiter SHALL not modify alu_result except per REQ-020.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, last_grant=1 (requester 0 wins first tie), all outputs 0, latched regs 0.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation; no response issued after release.

Verification
REQ-028 req0 addu a=5 b=7 -> rsp0_valid at T+2, result 12, zero 0, err 0.
REQ-029 req0 and req1 valid same cycle after reset (subu 3-3, or 1|2) -> req0 served first (result 0, zero 1), then req1 (result 3); next tie grants req0 again.
REQ-030 rsp0_ready held low 4 cycles -> rsp0_valid and result stable all 4 cycles, req1_ready stays low.
REQ-031 req1 ctr=1100 -> rsp1_result 0, rsp1_zero 1, rsp1_err 1.
REQ-032 rst_n pulsed low in EXEC -> outputs 0 asynchronously, no rsp_valid after release, next req accepted normally.
REQ-033 req1 lui b=0x0000_1234 -> rsp1_result 0x1234_0000; alu_ctr 1011 only in EXEC cycle.
